// File: rtl/pivot_div_sequencer_pkg.sv
// pivot_div_sequencer_pkg
//   Shared types and constants for the pivot/divider sequencer slice:
//   - seq_state_t : sequencer FSM states
//   - F32_ZERO_MAG / F32_POS_INF : float32 magnitude-zero mask and +inf
//   - ptr_width() : FIFO pointer width for a given depth
package pivot_div_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_Z,
        ST_OUT
    } seq_state_t;

    localparam logic [30:0] F32_ZERO_MAG = 31'h0;
    localparam logic [31:0] F32_POS_INF  = 32'h7f80_0000;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pivot_div_sequencer_if.sv
// pivot_div_sequencer_if
//   Operand/result handshake bundle between the sequencer and the float32
//   divider wrapper. Transfers occur on cycles with stb=1 and ack=1.
//   master (sequencer): drives div_a/div_a_stb, div_b/div_b_stb, div_z_ack
//   slave  (divider)  : drives div_a_ack, div_b_ack, div_z/div_z_stb
interface pivot_div_sequencer_if;

    logic [31:0] div_a;
    logic        div_a_stb;
    logic        div_a_ack;
    logic [31:0] div_b;
    logic        div_b_stb;
    logic        div_b_ack;
    logic [31:0] div_z;
    logic        div_z_stb;
    logic        div_z_ack;

    modport master (
        output div_a, div_a_stb, input div_a_ack,
        output div_b, div_b_stb, input div_b_ack,
        input  div_z, div_z_stb, output div_z_ack
    );

    modport slave (
        input  div_a, div_a_stb, output div_a_ack,
        input  div_b, div_b_stb, output div_b_ack,
        output div_z, div_z_stb, input div_z_ack
    );

endinterface

// File: rtl/pivot_div_sequencer_fifo.sv
// sync_fifo
//   Single-clock FIFO, DEPTH a power of two, pointers wrap modulo DEPTH.
//   Ports: clk, rst (async active-low), push/wr_data, pop/rd_data (head,
//   valid while !empty), full, empty, count (0..DEPTH).
//   Caller guarantees no push when full and no pop when empty.
module sync_fifo
    import pivot_div_sequencer_pkg::*;
#(
    parameter  int unsigned WIDTH = 48,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pivot_div_sequencer.sv
// pivot_div_sequencer
//   Holds one float32 pivot, queues indexed numerators, issues each
//   (numerator, pivot) pair to the divider and re-emits the quotient with
//   its index. One divide in flight, so results leave in FIFO order.
//   Ports:
//     clk, rst (async active-low)
//     pivot_data/pivot_valid/pivot_ready : pivot load (only when idle+empty)
//     pivot_zero                         : loaded pivot is +/-0
//     num_data/num_idx/num_valid/num_ready : numerator stream into FIFO
//     div (master)                       : divider operand/result handshakes
//     q_data/q_idx/q_valid/q_ready       : quotient stream out
//     busy                               : FSM active or FIFO non-empty
module pivot_div_sequencer
    import pivot_div_sequencer_pkg::*;
#(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pivot_data,
    input  logic                  pivot_valid,
    output logic                  pivot_ready,
    output logic                  pivot_zero,
    input  logic [31:0]           num_data,
    input  logic [IDX_W-1:0]      num_idx,
    input  logic                  num_valid,
    output logic                  num_ready,
    pivot_div_sequencer_if.master div,
    output logic [31:0]           q_data,
    output logic [IDX_W-1:0]      q_idx,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic                  busy
);

    localparam int unsigned ENT_W = 32 + IDX_W;
    localparam int unsigned CNT_W = ptr_width(DEPTH) + 1;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [31:0]      pivot_q;
    logic             pivot_loaded;
    logic [31:0]      opnd_data;
    logic [IDX_W-1:0] opnd_idx;
    logic             a_done;
    logic             b_done;
    logic             a_fire;
    logic             b_fire;
    logic             z_fire;
    logic             push;
    logic             pop;
    logic             can_issue;
    logic             pivot_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [ENT_W-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({num_data, num_idx}),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign num_ready  = ~fifo_full;
    assign push       = num_valid & ~fifo_full;
    assign can_issue  = pivot_loaded & ~fifo_empty;
    assign pivot_fire = pivot_valid & pivot_ready;
    assign a_fire     = div.div_a_stb & div.div_a_ack;
    assign b_fire     = div.div_b_stb & div.div_b_ack;
    assign z_fire     = div.div_z_stb & div.div_z_ack;
    assign div.div_a  = opnd_data;
    assign div.div_b  = pivot_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (can_issue) state_nxt = ST_SEND;
            // Each port may finish on an earlier cycle or on this one.
            ST_SEND:   if ((a_done | a_fire) && (b_done | b_fire)) state_nxt = ST_WAIT_Z;
            ST_WAIT_Z: if (div.div_z_stb) state_nxt = ST_OUT;
            ST_OUT:    if (q_ready) state_nxt = can_issue ? ST_SEND : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        div.div_a_stb = 1'b0;
        div.div_b_stb = 1'b0;
        div.div_z_ack = 1'b0;
        q_valid       = 1'b0;
        pivot_ready   = 1'b0;
        pop           = 1'b0;
        busy          = (state != ST_IDLE) || (fifo_count != '0);
        case (state)
            ST_IDLE: begin
                pivot_ready = fifo_empty;
                pop         = can_issue;
            end
            ST_SEND: begin
                div.div_a_stb = ~a_done;
                div.div_b_stb = ~b_done;
            end
            ST_WAIT_Z: div.div_z_ack = 1'b1;
            ST_OUT: begin
                q_valid = 1'b1;
                // Pop alongside acceptance so the next divide issues back-to-back.
                pop     = can_issue & q_ready;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pivot_q      <= '0;
            pivot_loaded <= 1'b0;
            pivot_zero   <= 1'b0;
            opnd_data    <= '0;
            opnd_idx     <= '0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
            q_data       <= '0;
            q_idx        <= '0;
        end else begin
            if (pivot_fire) begin
                pivot_q      <= pivot_data;
                pivot_loaded <= 1'b1;
                pivot_zero   <= (pivot_data[30:0] == F32_ZERO_MAG);
            end
            if (pop) begin
                {opnd_data, opnd_idx} <= fifo_head;
                a_done                <= 1'b0;
                b_done                <= 1'b0;
            end else begin
                if (a_fire) a_done <= 1'b1;
                if (b_fire) b_done <= 1'b1;
            end
            if (z_fire) begin
                q_data <= div.div_z;
                q_idx  <= opnd_idx;
            end
        end
    end

endmodule

// File: tb/tb_pivot_div_sequencer.sv
// tb_pivot_div_sequencer
//   Directed bench for pivot_div_sequencer with a behavioural divider on
//   the slave side of the interface and a quotient consumer.
module tb_pivot_div_sequencer;
    import pivot_div_sequencer_pkg::*;

    localparam int unsigned IDX_W = 16;
    localparam int unsigned DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       pivot_data;
    logic              pivot_valid;
    logic              pivot_ready;
    logic              pivot_zero;
    logic [31:0]       num_data;
    logic [IDX_W-1:0]  num_idx;
    logic              num_valid;
    logic              num_ready;
    logic [31:0]       q_data;
    logic [IDX_W-1:0]  q_idx;
    logic              q_valid;
    logic              q_ready;
    logic              busy;

    always #5 clk = ~clk;

    pivot_div_sequencer_if div_if ();

    pivot_div_sequencer #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pivot_data  (pivot_data),
        .pivot_valid (pivot_valid),
        .pivot_ready (pivot_ready),
        .pivot_zero  (pivot_zero),
        .num_data    (num_data),
        .num_idx     (num_idx),
        .num_valid   (num_valid),
        .num_ready   (num_ready),
        .div         (div_if),
        .q_data      (q_data),
        .q_idx       (q_idx),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .busy        (busy)
    );

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- divider model ----------------
    int unsigned a_lat = 1;
    int unsigned b_lat = 1;
    int unsigned z_lat = 0;

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] inf;
        inf = F32_POS_INF;
        if (b[30:0] == F32_ZERO_MAG) return {a[31] ^ b[31], inf[30:0]};
        if (b == 32'h4000_0000)      return a - 32'h0080_0000;
        return 32'h7fc0_0000;
    endfunction

    initial begin : divider_model
        int unsigned a_cnt, b_cnt, z_cnt;
        logic        a_got, b_got, resp;
        logic [31:0] a_cap, b_cap;
        a_cnt = 0; b_cnt = 0; z_cnt = 0;
        a_got = 1'b0; b_got = 1'b0; resp = 1'b0;
        a_cap = '0; b_cap = '0;
        div_if.div_a_ack = 1'b0;
        div_if.div_b_ack = 1'b0;
        div_if.div_z     = '0;
        div_if.div_z_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                a_cnt = 0; b_cnt = 0; z_cnt = 0;
                a_got = 1'b0; b_got = 1'b0; resp = 1'b0;
                div_if.div_a_ack = 1'b0;
                div_if.div_b_ack = 1'b0;
                div_if.div_z_stb = 1'b0;
                continue;
            end
            if (!resp) begin
                if (div_if.div_a_ack) begin
                    a_got = 1'b1;
                    div_if.div_a_ack = 1'b0;
                end else if (div_if.div_a_stb && !a_got) begin
                    a_cnt++;
                    if (a_cnt == 1) a_cap = div_if.div_a;
                    if (a_cnt >= a_lat) div_if.div_a_ack = 1'b1;
                end
                if (div_if.div_b_ack) begin
                    b_got = 1'b1;
                    div_if.div_b_ack = 1'b0;
                end else if (div_if.div_b_stb && !b_got) begin
                    b_cnt++;
                    if (b_cnt == 1) b_cap = div_if.div_b;
                    if (b_cnt >= b_lat) div_if.div_b_ack = 1'b1;
                end
                if (a_got && b_got) begin
                    resp  = 1'b1;
                    z_cnt = 0;
                end
            end
            if (resp) begin
                if (div_if.div_z_stb) begin
                    div_if.div_z_stb = 1'b0;
                    a_cnt = 0; b_cnt = 0;
                    a_got = 1'b0; b_got = 1'b0; resp = 1'b0;
                end else if (z_cnt >= z_lat) begin
                    check_eq("model_z_ack", {63'd0, div_if.div_z_ack}, 64'd1);
                    div_if.div_z     = div_model(a_cap, b_cap);
                    div_if.div_z_stb = 1'b1;
                end else begin
                    z_cnt++;
                end
            end
        end
    end

    // ---------------- quotient consumer ----------------
    int unsigned q_mode = 1;   // 0: hold off, 1: always ready, 2: random
    logic [31:0]      rx_data [$];
    logic [IDX_W-1:0] rx_idx  [$];

    initial begin : consumer
        q_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (q_mode)
                0:       q_ready = 1'b0;
                1:       q_ready = 1'b1;
                default: q_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst && q_valid && q_ready) begin
                rx_data.push_back(q_data);
                rx_idx.push_back(q_idx);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_pivot(input logic [31:0] d);
        pivot_data  = d;
        pivot_valid = 1'b1;
        @(negedge clk);
        pivot_valid = 1'b0;
    endtask

    task automatic push_num(input logic [31:0] d, input logic [IDX_W-1:0] i);
        int unsigned n;
        n = 0;
        num_data  = d;
        num_idx   = i;
        num_valid = 1'b1;
        while (!num_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_timeout", {63'd0, num_ready}, 64'd1);
        @(negedge clk);
        num_valid = 1'b0;
    endtask

    task automatic wait_rx(input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget && rx_data.size() < n; i++) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_idx.delete();
    endtask

    // ---------------- test vectors ----------------
    logic [31:0] t2_num [9] = '{32'h3f80_0000, 32'h4000_0000, 32'h4040_0000,
                                32'h4080_0000, 32'h40a0_0000, 32'h40c0_0000,
                                32'h40e0_0000, 32'h4100_0000, 32'h4110_0000};
    logic [31:0] t2_exp [9] = '{32'h3f00_0000, 32'h3f80_0000, 32'h3fc0_0000,
                                32'h4000_0000, 32'h4020_0000, 32'h4040_0000,
                                32'h4060_0000, 32'h4080_0000, 32'h4090_0000};

    int a_last, b_last, z_first, a_hi, b_hi, overlap, stb_seen;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        pivot_data  = '0;
        pivot_valid = 1'b0;
        num_data    = '0;
        num_idx     = '0;
        num_valid   = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_q_valid",     {63'd0, q_valid},          64'd0);
        check_eq("rst_a_stb",       {63'd0, div_if.div_a_stb}, 64'd0);
        check_eq("rst_b_stb",       {63'd0, div_if.div_b_stb}, 64'd0);
        check_eq("rst_z_ack",       {63'd0, div_if.div_z_ack}, 64'd0);
        check_eq("rst_busy",        {63'd0, busy},             64'd0);
        check_eq("rst_pivot_zero",  {63'd0, pivot_zero},       64'd0);
        check_eq("rst_pivot_ready", {63'd0, pivot_ready},      64'd1);
        check_eq("rst_num_ready",   {63'd0, num_ready},        64'd1);
        check_eq("rst_q_data",      {32'd0, q_data},           64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: 25.0 / 2.0 = 12.5, single result
        a_lat = 2; b_lat = 3; z_lat = 1; q_mode = 1;
        clear_rx();
        load_pivot(32'h4000_0000);
        check_eq("t1_pivot_zero", {63'd0, pivot_zero}, 64'd0);
        push_num(32'h41c8_0000, 16'd5);
        wait_rx(1, 100);
        repeat (10) @(negedge clk);
        check_eq("t1_rx_count", 64'(rx_data.size()), 64'd1);
        if (rx_data.size() >= 1) begin
            check_eq("t1_q_data", {32'd0, rx_data[0]}, 64'h4148_0000);
            check_eq("t1_q_idx",  {48'd0, rx_idx[0]},  64'd5);
        end
        check_eq("t1_idle_busy", {63'd0, busy}, 64'd0);

        // 3: A acked 4 cycles before B
        a_lat = 1; b_lat = 5; z_lat = 0;
        clear_rx();
        push_num(32'h4080_0000, 16'd33);
        a_last = -1; b_last = -1; z_first = -1; a_hi = 0; b_hi = 0; overlap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_if.div_a_stb) begin a_last = i; a_hi++; end
            if (div_if.div_b_stb) begin b_last = i; b_hi++; end
            if (div_if.div_z_ack && div_if.div_b_stb) overlap++;
            if (div_if.div_z_ack && z_first < 0) z_first = i;
        end
        check_eq("t3_a_stb_cycles", 64'(a_hi), 64'd1);
        check_eq("t3_b_stb_cycles", 64'(b_hi), 64'd5);
        check_eq("t3_b_after_a",    64'(b_last - a_last), 64'd4);
        check_eq("t3_waitz_after_b", 64'(z_first), 64'(b_last + 1));
        check_eq("t3_waitz_overlap", 64'(overlap), 64'd0);
        check_eq("t3_rx_count", 64'(rx_data.size()), 64'd1);
        if (rx_data.size() >= 1) begin
            check_eq("t3_q_data", {32'd0, rx_data[0]}, 64'h4000_0000);
            check_eq("t3_q_idx",  {48'd0, rx_idx[0]},  64'd33);
        end

        // 2 + 6: fill FIFO behind a stalled result, ignored pivot, random drain
        a_lat = 1; b_lat = 2; z_lat = 2; q_mode = 0;
        clear_rx();
        for (int k = 0; k < 9; k++) push_num(t2_num[k], IDX_W'(10 + k));
        check_eq("t2_num_ready_full", {63'd0, num_ready}, 64'd0);
        check_eq("t2_fifo_count", 64'(dut.u_fifo.count), 64'd8);
        check_eq("t6_pivot_ready_busy", {63'd0, pivot_ready}, 64'd0);
        check_eq("t6_busy", {63'd0, busy}, 64'd1);
        load_pivot(32'h4040_0000);
        q_mode = 2;
        wait_rx(9, 2000);
        repeat (10) @(negedge clk);
        check_eq("t2_rx_count", 64'(rx_data.size()), 64'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < rx_data.size()) begin
                check_eq($sformatf("t2_q_data_%0d", k), {32'd0, rx_data[k]}, {32'd0, t2_exp[k]});
                check_eq($sformatf("t2_q_idx_%0d", k),  {48'd0, rx_idx[k]},  64'(10 + k));
            end
        end

        // 4: -0.0 pivot, result passes through
        q_mode = 1;
        clear_rx();
        check_eq("t4_pivot_ready", {63'd0, pivot_ready}, 64'd1);
        load_pivot(32'h8000_0000);
        check_eq("t4_pivot_zero", {63'd0, pivot_zero}, 64'd1);
        push_num(32'h3f80_0000, 16'd7);
        wait_rx(1, 100);
        check_eq("t4_rx_count", 64'(rx_data.size()), 64'd1);
        if (rx_data.size() >= 1) begin
            check_eq("t4_q_data", {32'd0, rx_data[0]}, 64'hff80_0000);
            check_eq("t4_q_idx",  {48'd0, rx_idx[0]},  64'd7);
        end
        repeat (3) @(negedge clk);
        load_pivot(32'h0000_0001);
        check_eq("t4_denorm_not_zero", {63'd0, pivot_zero}, 64'd0);

        // 5: reset while waiting for z with 3 queued
        load_pivot(32'h4000_0000);
        a_lat = 1; b_lat = 1; z_lat = 50;
        clear_rx();
        for (int k = 0; k < 4; k++) push_num(32'h4000_0000, IDX_W'(40 + k));
        check_eq("t5_in_wait_z", {63'd0, div_if.div_z_ack}, 64'd1);
        check_eq("t5_queued", 64'(dut.u_fifo.count), 64'd3);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_z_ack",       {63'd0, div_if.div_z_ack}, 64'd0);
        check_eq("t5_rst_a_stb",       {63'd0, div_if.div_a_stb}, 64'd0);
        check_eq("t5_rst_busy",        {63'd0, busy},             64'd0);
        check_eq("t5_rst_q_data",      {32'd0, q_data},           64'd0);
        check_eq("t5_rst_pivot_ready", {63'd0, pivot_ready},      64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_pivot_ready", {63'd0, pivot_ready},       64'd1);
        check_eq("t5_busy",        {63'd0, busy},              64'd0);
        check_eq("t5_pivot_loaded", {63'd0, dut.pivot_loaded}, 64'd0);
        check_eq("t5_fifo_empty",  64'(dut.u_fifo.count),      64'd0);
        push_num(32'h3f80_0000, 16'd99);
        stb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (div_if.div_a_stb || div_if.div_b_stb) stb_seen++;
        end
        check_eq("t5_no_issue", 64'(stb_seen), 64'd0);
        check_eq("t5_busy_queued", {63'd0, busy}, 64'd1);
        check_eq("t5_rx_none", 64'(rx_data.size()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
